// File: rtl/ram_bus_ctrl.sv
// ram_bus_ctrl: picoRV32 native-bus bridge to a single-port synchronous RAM window.
// Defining RAM_BUS_CTRL_RMW_EN merges partial-strobe writes by read-modify-write.
module ram_bus_ctrl #(
   parameter int unsigned ADDR_BITS = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 mem_valid,
   input  logic [31:0]          mem_addr,
   input  logic [31:0]          mem_wdata,
   input  logic [3:0]           mem_wstrb,
   output logic                 mem_ready,
   output logic [31:0]          mem_rdata,
   output logic                 ram_wen,
   output logic [ADDR_BITS-1:0] ram_addr,
   output logic [31:0]          ram_wdata,
   input  logic [31:0]          ram_rdata
);

   typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWrite, StAck} state_e;

   state_e                 state_q, state_d;
   logic                   mem_ready_d;
   logic [31:0]            mem_rdata_d;
   logic                   ram_wen_d;
   logic [ADDR_BITS-1:0]   ram_addr_d;
   logic [31:0]            ram_wdata_d;
   logic                   sel;
   logic                   unused_addr_bits;

   assign sel = mem_valid && (mem_addr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
   assign unused_addr_bits = ^mem_addr[1:0];

`ifdef RAM_BUS_CTRL_RMW_EN
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] merged;

   // New bytes where strobed, otherwise keep the word just read back.
   always_comb begin
      merged = ram_rdata;
      for (int i = 0; i < 4; i++) begin
         if (wstrb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
      end
   end
`endif

   always_comb begin
      state_d     = state_q;
      mem_ready_d = 1'b0;
      mem_rdata_d = mem_rdata;
      ram_wen_d   = 1'b0;
      ram_addr_d  = ram_addr;
      ram_wdata_d = ram_wdata;
`ifdef RAM_BUS_CTRL_RMW_EN
      wstrb_d     = wstrb_q;
      wdata_d     = wdata_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (sel) begin
               ram_addr_d = mem_addr[ADDR_BITS+1:2];
`ifdef RAM_BUS_CTRL_RMW_EN
               wstrb_d = mem_wstrb;
               wdata_d = mem_wdata;
               if (mem_wstrb == 4'hF) begin
`else
               if (mem_wstrb != 4'h0) begin
`endif
                  ram_wen_d   = 1'b1;
                  ram_wdata_d = mem_wdata;
                  state_d     = StWrite;
               end else begin
                  state_d = StRaddr;
               end
            end
         end
         StRaddr: state_d = StRdata;
         StRdata: begin
`ifdef RAM_BUS_CTRL_RMW_EN
            if (wstrb_q != 4'h0) begin
               ram_wen_d   = 1'b1;
               ram_wdata_d = merged;
               state_d     = StWrite;
            end else begin
               mem_rdata_d = ram_rdata;
               mem_ready_d = 1'b1;
               state_d     = StAck;
            end
`else
            mem_rdata_d = ram_rdata;
            mem_ready_d = 1'b1;
            state_d     = StAck;
`endif
         end
         StWrite: begin
            mem_ready_d = 1'b1;
            state_d     = StAck;
         end
         StAck:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= StIdle;
         mem_ready <= 1'b0;
         mem_rdata <= '0;
         ram_wen   <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
`ifdef RAM_BUS_CTRL_RMW_EN
         wstrb_q   <= '0;
         wdata_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         mem_ready <= mem_ready_d;
         mem_rdata <= mem_rdata_d;
         ram_wen   <= ram_wen_d;
         ram_addr  <= ram_addr_d;
         ram_wdata <= ram_wdata_d;
`ifdef RAM_BUS_CTRL_RMW_EN
         wstrb_q   <= wstrb_d;
         wdata_q   <= wdata_d;
`endif
      end
   end

endmodule

// File: doc/ram_bus_ctrl.md
RAM_BUS_CTRL -- requirements
Module: ram_bus_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 8, giving the word-address width of the attached synchronous RAM (8 = 256 words, 9 = 512 words).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte base address of the RAM window; its low ADDR_BITS+2 bits are ignored.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port mem_valid, input, 1 bit: CPU request valid (picoRV32 native bus).
REQ-006 The block SHALL have port mem_addr, input, 32 bits: CPU byte address.
REQ-007 The block SHALL have port mem_wdata, input, 32 bits: CPU write data.
REQ-008 The block SHALL have port mem_wstrb, input, 4 bits: byte write strobes; 0 means read.
REQ-009 The block SHALL have port mem_ready, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port mem_rdata, output, 32 bits: registered read data.
REQ-011 The block SHALL have port ram_wen, output, 1 bit: RAM word write enable.
REQ-012 The block SHALL have port ram_addr, output, ADDR_BITS bits: RAM word address.
REQ-013 The block SHALL have port ram_wdata, output, 32 bits: RAM write data.
REQ-014 The block SHALL have port ram_rdata, input, 32 bits: RAM read data, registered inside the RAM one clock after ram_addr.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 The block SHALL implement the states IDLE, RADDR, RDATA, WRITE and ACK.
REQ-017 A request SHALL be selected when mem_valid=1 and mem_addr[31:ADDR_BITS+2] equals BASE_ADDR[31:ADDR_BITS+2].
REQ-018 In IDLE with no selected request, the block SHALL stay in IDLE with ram_wen=0 and mem_ready=0; out-of-window requests SHALL get no response.
REQ-019 In IDLE with a selected request at edge N, ram_addr SHALL load mem_addr[ADDR_BITS+1:2] at edge N.
REQ-020 Read (wstrb=0): the state SHALL step IDLE->RADDR->RDATA->ACK; at edge N+2 mem_rdata SHALL load ram_rdata and mem_ready SHALL be 1 for the following cycle only.
REQ-021 Full write (wstrb=4'hF): the state SHALL step IDLE->WRITE->ACK; ram_wen=1 and ram_wdata=mem_wdata SHALL hold for exactly the cycle after edge N; mem_ready SHALL be high in the cycle after edge N+1.
REQ-022 Partial write (wstrb not 0 and not F): the state SHALL step IDLE->RADDR->RDATA->WRITE->ACK; in WRITE, ram_wdata lane i SHALL be mem_wdata lane i where wstrb[i]=1, else ram_rdata lane i; mem_ready SHALL be high in the cycle after edge N+3.
REQ-023 ACK SHALL always return to IDLE, giving at least one idle cycle between consecutive mem_ready pulses.
REQ-024 mem_rdata SHALL hold its last value through write transactions.
REQ-025 mem_wdata, mem_wstrb and mem_addr SHALL be sampled only in IDLE; changes to them, or a drop of mem_valid, mid-transaction SHALL NOT alter the transaction in progress.
REQ-026 ram_wen SHALL never be high for more than one consecutive cycle.
REQ-027 The block SHALL write at most once per transaction.

Reset
REQ-028 When resetn=0 at a rising edge, the state SHALL become IDLE and mem_ready, ram_wen, ram_addr, ram_wdata and mem_rdata SHALL all become 0.
REQ-029 Reset mid-transaction SHALL abort the transaction with no mem_ready pulse.
REQ-030 A write whose ram_wen was already high at the reset edge SHALL be allowed to complete in the RAM.
REQ-031 A request present in the first cycle after reset release SHALL be accepted normally.

Configuration
REQ-032 With macro RAM_BUS_CTRL_RMW_EN defined, partial writes SHALL use the read-modify-write sequence of REQ-022.
REQ-033 With RAM_BUS_CTRL_RMW_EN undefined, any nonzero wstrb SHALL be handled as a full write per REQ-021 (whole mem_wdata written), and RADDR/RDATA SHALL be used only for reads.

Verification
REQ-034 Read, RAM word 5 = 32'hAABBCCDD: mem_addr=32'h14, wstrb=0 -> mem_ready pulses once, 3 cycles after acceptance, with mem_rdata=32'hAABBCCDD.
REQ-035 Full write: addr 32'h20, wdata 32'h12345678, wstrb F -> a single ram_wen pulse at ram_addr 8; ready after 2 cycles; a read-back returns 32'h12345678.
REQ-036 RMW, word 8 = 32'h12345678: wstrb 4'b0101, wdata 32'hFFFFFFFF -> RAM holds 32'h12FF56FF, ready after 4 cycles; without the macro -> RAM holds 32'hFFFFFFFF, ready after 2 cycles.
REQ-037 Out of window: mem_addr=32'h0000_0400 with ADDR_BITS=8, BASE 0 -> no mem_ready and no ram_wen for 10 cycles.
REQ-038 Reset: resetn=0 in RDATA of a read -> no mem_ready, all outputs 0; a new read in the first cycle after release completes normally.
REQ-039 Back-to-back: two reads with mem_valid held high -> two single-cycle ready pulses separated by at least one low cycle, with correct data for each.
